// File: rtl/main_memory_responder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | main_memory_responder                                                  |
// | Block-granular backing memory with programmable latency and a          |
// | four-phase request/ready handshake.                                    |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module main_memory_responder #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int MEM_DEPTH_WORDS = 1024,
  parameter int LATENCY         = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  rd_req,
  input  logic                                  wr_req,
  input  logic [ADDR_WIDTH-1:0]                 addr,
  input  logic [DATA_WIDTH*WORDS_PER_BLOCK-1:0] wr_block,
  output logic [DATA_WIDTH*WORDS_PER_BLOCK-1:0] rd_block,
  output logic                                  mem_ready,
  output logic                                  busy
);

  localparam int c_BLOCK_W    = DATA_WIDTH * WORDS_PER_BLOCK;
  localparam int c_NUM_BLOCKS = MEM_DEPTH_WORDS / WORDS_PER_BLOCK;
  localparam int c_OFF_W      = $clog2(WORDS_PER_BLOCK * 4);
  localparam int c_IDX_W      = (c_NUM_BLOCKS > 1) ? $clog2(c_NUM_BLOCKS) : 1;
  localparam int c_CNT_W      = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(LATENCY - 1);

  localparam logic [1:0] c_IDLE         = 2'd0;
  localparam logic [1:0] c_BUSY         = 2'd1;
  localparam logic [1:0] c_RESPOND      = 2'd2;
  localparam logic [1:0] c_WAIT_RELEASE = 2'd3;

  logic [1:0]           r_state;
  logic [1:0]           w_next_state;
  logic [c_CNT_W-1:0]   r_count;
  logic                 r_op_write;
  logic [c_IDX_W-1:0]   r_idx;
  logic [c_BLOCK_W-1:0] r_wdata;
  logic [c_BLOCK_W-1:0] r_rd_block;
  logic [ADDR_WIDTH-1:0] w_blk_full;
  logic [c_IDX_W-1:0]   w_idx;
  logic                 w_access;

  logic [c_BLOCK_W-1:0] r_mem [c_NUM_BLOCKS];

  // Out-of-range block numbers wrap onto the physical storage.
  assign w_blk_full = addr >> c_OFF_W;
  assign w_idx      = c_IDX_W'(w_blk_full % ADDR_WIDTH'(c_NUM_BLOCKS));
  assign w_access   = (r_state == c_BUSY) && (r_count == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE:         if (wr_req || rd_req) w_next_state = c_BUSY;
      c_BUSY:         if (r_count == '0) w_next_state = c_RESPOND;
      c_RESPOND:      w_next_state = c_WAIT_RELEASE;
      c_WAIT_RELEASE: if (!rd_req && !wr_req) w_next_state = c_IDLE;
      default:        w_next_state = c_IDLE;
    endcase
  end

  always_comb begin
    mem_ready = (r_state == c_RESPOND);
    busy      = (r_state != c_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count    <= '0;
      r_op_write <= 1'b0;
      r_idx      <= '0;
      r_wdata    <= '0;
      r_rd_block <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          // A simultaneous read is dropped in favour of the write.
          if (wr_req) begin
            r_op_write <= 1'b1;
            r_idx      <= w_idx;
            r_wdata    <= wr_block;
            r_count    <= c_CNT_INIT;
          end else if (rd_req) begin
            r_op_write <= 1'b0;
            r_idx      <= w_idx;
            r_count    <= c_CNT_INIT;
          end
        end
        c_BUSY: begin
          if (r_count != '0) begin
            r_count <= r_count - 1'b1;
          end else if (!r_op_write) begin
            r_rd_block <= r_mem[r_idx];
          end
        end
        default: ;
      endcase
    end
  end

  // Storage is deliberately not reset; a reset before the commit edge drops the write.
  always_ff @(posedge clk) begin
    if (!rst && w_access && r_op_write) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  assign rd_block = r_rd_block;

endmodule
`default_nettype wire

// File: tb/tb_main_memory_responder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_main_memory_responder                                               |
// | Directed scoreboard bench for the block memory responder.              |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_main_memory_responder;

  localparam int c_AW  = 32;
  localparam int c_DW  = 32;
  localparam int c_WPB = 4;
  localparam int c_MDW = 1024;
  localparam int c_LAT = 4;
  localparam int c_BW  = c_DW * c_WPB;
  localparam int c_NB  = c_MDW / c_WPB;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            rd_req = 1'b0;
  logic            wr_req = 1'b0;
  logic [c_AW-1:0] addr = '0;
  logic [c_BW-1:0] wr_block = '0;
  logic [c_BW-1:0] rd_block;
  logic            mem_ready;
  logic            busy;

  int checks = 0;
  int errors = 0;

  logic [c_BW-1:0] model_mem [int];
  logic [c_BW-1:0] model_last_rd;
  logic [c_BW-1:0] exp_q [$];

  main_memory_responder #(
    .ADDR_WIDTH(c_AW), .DATA_WIDTH(c_DW), .WORDS_PER_BLOCK(c_WPB),
    .MEM_DEPTH_WORDS(c_MDW), .LATENCY(c_LAT)
  ) dut (
    .clk(clk), .rst(rst), .rd_req(rd_req), .wr_req(wr_req), .addr(addr),
    .wr_block(wr_block), .rd_block(rd_block), .mem_ready(mem_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [c_BW-1:0] obs, input logic [c_BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int blk(input logic [c_AW-1:0] a);
    return int'((a >> 4) % c_NB);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one transaction, predicts its rd_block, checks latency and pulse width,
  // optionally holds the request after completion, then releases.
  task automatic txn(input logic rd, input logic wr, input logic [c_AW-1:0] a,
                     input logic [c_BW-1:0] d, input int hold, input string tag);
    int cycles;
    logic [c_BW-1:0] exp;
    rd_req = rd; wr_req = wr; addr = a; wr_block = d;
    if (wr) model_mem[blk(a)] = d;
    else model_last_rd = model_mem[blk(a)];
    exp_q.push_back(model_last_rd);
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (!mem_ready && cycles < 50);
    check({tag, "_latency"}, c_BW'(cycles), c_BW'(c_LAT + 1));
    if (exp_q.size() == 0) check({tag, "_queue"}, 1, 0);
    else begin
      exp = exp_q.pop_front();
      check({tag, "_rd_block"}, rd_block, exp);
    end
    rd_req = 1'b0; wr_req = 1'b0;
    if (hold > 0) rd_req = 1'b1;
    step();
    check({tag, "_pulse_width"}, c_BW'(mem_ready), 0);
    check({tag, "_busy_wait"}, c_BW'(busy), 1);
    for (int i = 1; i < hold; i++) begin
      step();
      check({tag, "_hold_ready"}, c_BW'(mem_ready), 0);
      check({tag, "_hold_busy"}, c_BW'(busy), 1);
    end
    rd_req = 1'b0;
    step();
    check({tag, "_idle"}, c_BW'(busy), 0);
  endtask

  initial begin
    logic [c_BW-1:0] k20;
    model_last_rd = '0;

    // Reset with a pending read: nothing may start.
    rst = 1'b1; rd_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_ready", c_BW'(mem_ready), 0);
      check("rst_busy", c_BW'(busy), 0);
      check("rst_rd_block", rd_block, 0);
    end
    rd_req = 1'b0; rst = 1'b0;
    step();
    check("post_rst_busy", c_BW'(busy), 0);

    txn(1'b0, 1'b1, 32'h40, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 0, "wr40");
    txn(1'b1, 1'b0, 32'h4C, '0, 10, "rd4c_held");
    txn(1'b1, 1'b1, 32'h80, 128'h80808080_81818181_82828282_83838383, 0, "simul");
    txn(1'b1, 1'b0, 32'h80, '0, 0, "rd80");
    txn(1'b0, 1'b1, 32'h1000, {4{32'h12345678}}, 0, "wr1000");
    txn(1'b1, 1'b0, 32'h0, '0, 0, "rd0_wrap");

    k20 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    txn(1'b0, 1'b1, 32'h20, k20, 0, "wr20");

    // Abort a write once its counter has reached 1.
    wr_req = 1'b1; addr = 32'h20; wr_block = '1;
    step();
    step();
    step();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("abort_ready", c_BW'(mem_ready), 0);
      check("abort_busy", c_BW'(busy), 0);
    end
    wr_req = 1'b0; rst = 1'b0;
    model_last_rd = '0;
    check("abort_rd_block", rd_block, 0);
    step();
    txn(1'b1, 1'b0, 32'h20, '0, 0, "rd20_after_abort");
    check("rd20_value", rd_block, k20);

    check("queue_drained", c_BW'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
